// File: rtl/sram_bank_array.sv
`default_nettype none
// ============================================================================
// Module   : sram_bank_array
// Purpose  : Multi-bank single-port SRAM used as the storage backend of the
//            DRAM emulator. NBANKS independent banks sit behind one request
//            port. Writes have per-byte enables. Reads return through an
//            RD_LAT-deep pipeline with a one-cycle response strobe. After
//            every reset, a hardware sweep zeroes all banks before any
//            request is accepted.
//
// Ports    : clk        rising-edge clock
//            rst        asynchronous active-high reset
//            req_valid  request present
//            req_ready  request can be accepted (mirrors init_done)
//            req_we     1 = write, 0 = read
//            req_bank   target bank
//            req_addr   word address within the bank
//            req_be     byte enables for writes (bit i -> data[8i+7:8i])
//            req_wdata  write data
//            rsp_valid  one-cycle pulse, rsp_data carries a read result
//            rsp_data   read data, holds its value between responses
//            init_done  zero-initialisation sweep complete
//
// Revision : 1.0 - initial multi-bank release
// ============================================================================
module sram_bank_array #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 1024,
    parameter int NBANKS = 4,
    parameter int RD_LAT = 2
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          req_valid,
    output logic                                          req_ready,
    input  logic                                          req_we,
    input  logic [((NBANKS > 1) ? $clog2(NBANKS) : 1)-1:0] req_bank,
    input  logic [$clog2(DEPTH)-1:0]                      req_addr,
    input  logic [WIDTH/8-1:0]                            req_be,
    input  logic [WIDTH-1:0]                              req_wdata,
    output logic                                          rsp_valid,
    output logic [WIDTH-1:0]                              rsp_data,
    output logic                                          init_done
);

    localparam int c_AW     = $clog2(DEPTH);
    localparam int c_BW     = (NBANKS > 1) ? $clog2(NBANKS) : 1;
    localparam int c_NBYTES = WIDTH / 8;

    localparam logic [c_AW-1:0] c_LAST_ADDR = c_AW'(DEPTH - 1);
    localparam logic [31:0]     c_DEPTH32   = DEPTH;
    localparam logic [31:0]     c_NBANKS32  = NBANKS;

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t          r_state;
    logic [c_AW-1:0] r_cnt;
    logic            r_init_done;

    // Request decode
    logic w_accept;
    logic w_rd_accept;
    logic w_bank_ok;
    logic w_addr_ok;

    // Shared memory port, driven by either the sweep or the requester
    logic [NBANKS-1:0]   w_mem_we;
    logic [NBANKS-1:0]   w_mem_re;
    logic [c_AW-1:0]     w_mem_addr;
    logic [WIDTH-1:0]    w_mem_wdata;
    logic [c_NBYTES-1:0] w_mem_be;

    // Per-bank registered read data
    logic [NBANKS-1:0][WIDTH-1:0] w_bank_q;

    // Read stage 1 bookkeeping (travels alongside the array read register)
    logic            r_s1_vld;
    logic            r_s1_ok;
    logic [c_BW-1:0] r_s1_bank;
    logic [WIDTH-1:0] w_s1_data;

    // ------------------------------------------------------------------
    // Sweep / run FSM
    // The sweep writes address r_cnt on every edge spent in ST_INIT, so the
    // first edge after reset release writes address 0 and the edge that
    // writes DEPTH-1 also moves to ST_RUN. init_done is registered from the
    // state, so it rises one edge after ST_RUN is entered.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_INIT;
            r_cnt       <= '0;
            r_init_done <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_init_done <= 1'b0;
                    if (r_cnt == c_LAST_ADDR) begin
                        r_state <= ST_RUN;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    r_init_done <= 1'b1;
                end
                default: begin
                    r_state     <= ST_INIT;
                    r_init_done <= 1'b0;
                end
            endcase
        end
    end

    assign init_done = r_init_done;
    assign req_ready = r_init_done;

    // ------------------------------------------------------------------
    // Request decode. Range checks are done in 32 bits so that banks or
    // depths that exactly fill the index width do not wrap to zero.
    // ------------------------------------------------------------------
    assign w_accept    = req_valid && r_init_done;
    assign w_rd_accept = w_accept && !req_we;
    assign w_addr_ok   = ({{(32 - c_AW){1'b0}}, req_addr} < c_DEPTH32);
    assign w_bank_ok   = ({{(32 - c_BW){1'b0}}, req_bank} < c_NBANKS32);

    // Memory port steering: the sweep owns every bank while in ST_INIT,
    // otherwise an accepted in-range request addresses exactly one bank.
    // Out-of-range requests enable nothing.
    always_comb begin
        w_mem_we    = '0;
        w_mem_re    = '0;
        w_mem_addr  = req_addr;
        w_mem_wdata = req_wdata;
        w_mem_be    = req_be;
        if (r_state == ST_INIT) begin
            w_mem_we    = '1;
            w_mem_addr  = r_cnt;
            w_mem_wdata = '0;
            w_mem_be    = '1;
        end else if (w_accept && w_bank_ok && w_addr_ok) begin
            for (int b = 0; b < NBANKS; b++) begin
                if (req_bank == c_BW'(b)) begin
                    w_mem_we[b] = req_we;
                    w_mem_re[b] = !req_we;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Storage: one array per bank, byte-enabled write plus registered read
    // in a single reset-free process so that it maps onto block RAM.
    // The read register only loads on a read to its own bank, which keeps
    // the selected value stable between responses.
    // ------------------------------------------------------------------
    for (genvar b = 0; b < NBANKS; b++) begin : g_bank
        logic [WIDTH-1:0] r_mem [DEPTH];
        logic [WIDTH-1:0] r_q;

        always_ff @(posedge clk) begin
            if (w_mem_we[b]) begin
                for (int i = 0; i < c_NBYTES; i++) begin
                    if (w_mem_be[i]) begin
                        r_mem[w_mem_addr][8*i +: 8] <= w_mem_wdata[8*i +: 8];
                    end
                end
            end
            if (w_mem_re[b]) begin
                r_q <= r_mem[w_mem_addr];
            end
        end

        assign w_bank_q[b] = r_q;
    end

    // ------------------------------------------------------------------
    // Read stage 1: captured on the accepting edge together with the array
    // read. r_s1_ok gates the bank mux so that out-of-range reads (and the
    // state right after reset) present zero.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_vld  <= 1'b0;
            r_s1_ok   <= 1'b0;
            r_s1_bank <= '0;
        end else begin
            r_s1_vld <= w_rd_accept;
            if (w_rd_accept) begin
                r_s1_ok   <= w_bank_ok && w_addr_ok;
                r_s1_bank <= req_bank;
            end
        end
    end

    always_comb begin
        w_s1_data = '0;
        for (int b = 0; b < NBANKS; b++) begin
            if (r_s1_ok && (r_s1_bank == c_BW'(b))) begin
                w_s1_data = w_bank_q[b];
            end
        end
    end

    // ------------------------------------------------------------------
    // Output pipeline: RD_LAT-1 further register stages. Data registers
    // only load alongside a valid bit, so rsp_data holds the last result.
    // ------------------------------------------------------------------
    if (RD_LAT == 1) begin : g_lat1
        assign rsp_valid = r_s1_vld;
        assign rsp_data  = w_s1_data;
    end else begin : g_latn
        logic [RD_LAT-2:0] r_pv;
        logic [WIDTH-1:0]  r_pd [RD_LAT-1];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_pv <= '0;
                for (int k = 0; k < RD_LAT - 1; k++) begin
                    r_pd[k] <= '0;
                end
            end else begin
                r_pv[0] <= r_s1_vld;
                if (r_s1_vld) begin
                    r_pd[0] <= w_s1_data;
                end
                for (int k = 1; k < RD_LAT - 1; k++) begin
                    r_pv[k] <= r_pv[k-1];
                    if (r_pv[k-1]) begin
                        r_pd[k] <= r_pd[k-1];
                    end
                end
            end
        end

        assign rsp_valid = r_pv[RD_LAT-2];
        assign rsp_data  = r_pd[RD_LAT-2];
    end

endmodule
`default_nettype wire
